mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store (data) requester of the pipelined RV32I core.
- Grants one transaction at a time and alternates fairly when both requesters contend.
- Sequences the memory handshake, generates byte enables, and aligns and sign-extends load data according to MemSize and load_extend_sign from the control decoder.
- Flags misaligned accesses and memory timeouts.

Parameters:
- ADDR_W, 32, address width
- MAX_WAIT, 16, XFER cycles without mem_ready before the transfer aborts with an error

Ports:
- clock, input, 1, system clock
- reset, input, 1, asynchronous, active-high
- if_req, input, 1, fetch request; held until if_ack
- if_addr, input, ADDR_W, fetch address
- if_ack, output, 1, one-cycle pulse: fetch done
- if_rdata, output, 32, instruction word; valid with if_ack
- if_err, output, 1, valid with if_ack: misaligned or timeout
- d_req, input, 1, data request; held until d_ack
- d_wEn, input, 1, 1 = store, 0 = load
- d_addr, input, ADDR_W, byte address
- d_wdata, input, 32, store data, right-aligned
- d_size, input, 2, SIZE_BYTE / SIZE_HWORD / SIZE_WORD
- d_sign, input, 1, load sign-extend enable
- d_ack, output, 1, one-cycle pulse: data access done
- d_rdata, output, 32, aligned and extended load data; valid with d_ack
- d_err, output, 1, valid with d_ack
- mem_req, output, 1, memory request; held until mem_ready
- mem_wEn, output, 1, memory write
- mem_addr, output, ADDR_W, word-aligned address (low 2 bits = 0)
- mem_wdata, output, 32, lane-replicated store data
- mem_be, output, 4, byte enables
- mem_ready, input, 1, memory accepted the write or returned read data this cycle
- mem_rdata, input, 32, read word; valid when mem_ready

Behaviour:
- Reset is asynchronous. All outputs go to 0, state goes to IDLE, last_grant goes to IF. Reset during XFER abandons the access; no ack is issued.
- States:
  - IDLE: no transfer; evaluate requests
  - XFER: mem_req held high
  - RESP: the granted ack is high for exactly 1 cycle, then go to IDLE
- Requests are not sampled in RESP. This prevents a double grant while the requester is dropping its req.
- IDLE arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant the one that is not last_grant. After reset, data wins the first tie.
- On grant, latch all request fields and set last_grant.
- Misaligned requests go IDLE to RESP without any memory access, with err=1 and rdata=0:
  - fetch with addr[1:0] != 0
  - HWORD with addr[0] = 1
  - WORD with addr[1:0] != 0
  - d_size = 2'b11 is treated as misaligned
- Aligned requests go IDLE to XFER. mem_req is registered and asserted the cycle after the grant. mem_* outputs are driven from latched registers and stay stable for the whole XFER.
- Byte enables and write data:
  - BYTE: mem_be = 1 << addr[1:0]; wdata byte replicated 4x
  - HWORD: mem_be = 0011 or 1100 by addr[1]; halfword replicated 2x
  - WORD: mem_be = 1111
  - Loads use mem_be = 1111.
- XFER with mem_ready = 1: capture mem_rdata, go to RESP.
- Wait counter:
  - Counts XFER cycles.
  - When it reaches MAX_WAIT with mem_ready low: drop mem_req and go to RESP with err=1, rdata=0.
  - mem_ready arriving in the same cycle the count reaches MAX_WAIT counts as success.
- RESP load data:
  - Select the byte or halfword lane by latched addr[1:0].
  - Sign-extend if latched d_sign, else zero-extend.
  - WORD loads pass through unchanged.
  - Stores return d_rdata = 0.
  - Fetch returns the raw word.
- Latency: request seen in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 2 with zero-wait memory. Ack comes n cycles later for n wait cycles.
- Minimum spacing between back-to-back grants is 3 cycles (IDLE, XFER, RESP).

Decomposition:
- Shared package holds:
  - SIZE_BYTE = 2'b00, SIZE_HWORD = 2'b01, SIZE_WORD = 2'b10
  - state encodings IDLE / XFER / RESP
  - requester id (IF = 0, D = 1)
- One sub-module, mem_lane_align, is combinational:
  - store side: size + addr[1:0] + wdata in, mem_be + mem_wdata out
  - load side: size + addr[1:0] + sign + rdata in, aligned d_rdata out

Test Plan:
- Fetch only, addr 0x100, mem returns 0x00500093 with zero wait: mem_req at cycle 1; if_ack and if_rdata = 0x00500093 at cycle 2; if_err = 0.
- Both requests at cycle 0 after reset: data granted first; fetch granted in the next IDLE; the following tie goes to data again (alternation).
- lb at addr 0x203 with mem_rdata 0x80FF_FF7F: d_rdata = 0xFFFF_FF80. The same access as lbu gives 0x0000_0080. lh at 0x202 gives 0xFFFF_80FF.
- sb at addr 0x201 with d_wdata 0x12345678: mem_be = 0010, mem_wdata = 0x78787878, mem_addr = 0x200.
- lw at 0x102: no mem_req; d_ack at cycle 1 with d_err = 1, d_rdata = 0.
- mem_ready held low for MAX_WAIT = 16 cycles: mem_req drops and the ack comes with err = 1. Then assert reset mid-XFER on a new request: all outputs are 0 immediately and no ack follows.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: access sizes,
// arbiter states, requester ids and the alignment rule.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Size 2'b11 has no defined access width, so it is rejected like a misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE:  return 1'b0;
            SIZE_HWORD: return lo[0];
            SIZE_WORD:  return lo != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// and load lane selection with sign or zero extension.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        sign,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] ext_byte(input logic signed [7:0] v, input logic sgn);
        logic signed [31:0] sx;
        sx = 32'(v);
        return sgn ? $unsigned(sx) : {24'h0, v};
    endfunction

    function automatic logic [31:0] ext_half(input logic signed [15:0] v, input logic sgn);
        logic signed [31:0] sx;
        sx = 32'(v);
        return sgn ? $unsigned(sx) : {16'h0, v};
    endfunction

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        case (st_size)
            SIZE_BYTE: begin
                be        = 4'b0001 << st_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_HWORD: begin
                be        = st_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: ;
        endcase
    end

    assign byte_shift = rdata >> {ld_lo, 3'b000};
    assign half_shift = rdata >> {ld_lo[1], 4'b0000};

    always_comb begin
        ld_data = '0;
        case (ld_size)
            SIZE_BYTE:  ld_data = ext_byte(byte_shift[7:0], sign);
            SIZE_HWORD: ld_data = ext_half(half_shift[15:0], sign);
            SIZE_WORD:  ld_data = rdata;
            default:    ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fair two-requester arbiter in front of a single-port unified memory:
// grants fetch or load/store, runs the mem handshake with a timeout, aligns load data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_wEn,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_e            state, state_n;
    req_id_e           gid, last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic              resp_err;

    logic              take, pick_d, bad, done_ok, timeout, is_store;
    logic [ADDR_W-1:0] sel_addr;

    logic              lat_wen, lat_sign;
    logic [1:0]        lat_size, lat_lo;
    logic [31:0]       raw_q;

    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_data;

    assign sel_addr = pick_d ? d_addr : if_addr;
    assign is_store = pick_d && d_wEn;

    always_comb begin
        state_n = state;
        take    = 1'b0;
        pick_d  = 1'b0;
        bad     = 1'b0;
        done_ok = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    take    = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    pick_d  = d_req && (!if_req || last_grant == REQ_IF);
                    bad     = pick_d ? misaligned(d_size, d_addr[1:0]) : (if_addr[1:0] != 2'b00);
                    state_n = bad ? RESP : XFER;
                end
            end
            XFER: begin
                if (mem_ready) begin
                    done_ok = 1'b1;
                    state_n = RESP;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    timeout = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gid        <= REQ_IF;
            last_grant <= REQ_IF;
            wait_cnt   <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_wEn    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                gid        <= pick_d ? REQ_D : REQ_IF;
                last_grant <= pick_d ? REQ_D : REQ_IF;
                resp_err   <= bad;
                wait_cnt   <= '0;
                mem_req    <= !bad;
                if (!bad) begin
                    mem_wEn   <= is_store;
                    mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                    mem_be    <= is_store ? st_be : 4'b1111;
                    mem_wdata <= is_store ? st_wdata : '0;
                end
            end
            if (state == XFER) begin
                if (done_ok || timeout) mem_req <= 1'b0;
                if (timeout) resp_err <= 1'b1;
                else if (!done_ok) wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Request fields and the returned word are only observed while acked, so no reset.
    always_ff @(posedge clock) begin
        if (take) begin
            lat_wen  <= is_store;
            lat_size <= pick_d ? d_size : SIZE_WORD;
            lat_lo   <= sel_addr[1:0];
            lat_sign <= d_sign;
        end
        if (done_ok) raw_q <= mem_rdata;
    end

    mem_lane_align u_align (
        .st_size   (d_size),
        .st_lo     (d_addr[1:0]),
        .wdata     (d_wdata),
        .be        (st_be),
        .wdata_rep (st_wdata),
        .ld_size   (lat_size),
        .ld_lo     (lat_lo),
        .sign      (lat_sign),
        .rdata     (raw_q),
        .ld_data   (ld_data)
    );

    assign if_ack   = (state == RESP) && (gid == REQ_IF);
    assign d_ack    = (state == RESP) && (gid == REQ_D);
    assign if_err   = if_ack && resp_err;
    assign d_err    = d_ack && resp_err;
    assign if_rdata = (if_ack && !resp_err) ? raw_q : '0;
    assign d_rdata  = (d_ack && !resp_err && !lat_wen) ? ld_data : '0;

endmodule
